seg7_scan_mux: RTL
==================

# seg7_scan_mux

Parametrised, time-multiplexed N-digit seven-segment display driver: the successor of the fixed 4-digit display logic. It latches a packed hex value, per-digit decimal points and per-digit blanks, then scans one digit per slot. Each slot starts with an anti-ghosting dead time, and the driver supports optional leading-zero suppression and a selectable output polarity. It sits between the board-level top and the anode/segment pins, using the 50 MHz board clock.

## Interface

**Parameters**

- DIGITS, 4 — number of digits scanned (1..8).
- CLK_HZ, 50_000_000 — CLK frequency.
- SCAN_HZ, 1000 — full-frame refresh rate.
- DEAD_CYC, 1 — cycles of all-anodes-off at the start of each slot; must be less than SLOT.
- ACTIVE_LOW, 1 — 1 inverts the anode, segment and dp outputs.

**Ports**

- CLK in 1 — system clock, rising edge.
- RST_N in 1 — asynchronous, active-low reset.
- load in 1 — one-cycle strobe; captures value_in, dp_in and blank_in.
- value_in in 4*DIGITS — packed nibbles; nibble k drives digit k, and digit 0 is least significant.
- dp_in in DIGITS — per-digit decimal point request.
- blank_in in DIGITS — per-digit forced blank.
- lz_en in 1 — leading-zero suppression enable; sampled live each slot.
- an_out out DIGITS — digit enables, one-hot when active.
- seg_out out 7 — segments {g,f,e,d,c,b,a}.
- dp_out out 1 — decimal point.
- frame_out out 1 — one-cycle pulse when digit 0's slot begins.

## Operation

- **Derived constant:** SLOT = CLK_HZ/(SCAN_HZ*DIGITS), using integer division. Elaboration fails if SLOT < 2.
- **Prescaler:** counts 0..SLOT-1 and wraps. At terminal count, the digit index advances and wraps from DIGITS-1 to 0.
- **Shadow registers:** val_q, dp_q and blank_q load on load=1. They do not reach the pins directly.
- **Per-slot latch:** on the cycle the prescaler wraps, the next digit's nibble, dp, blank and suppression flag are copied into the slot registers. A load mid-slot therefore never changes the digit currently lit ("no tearing"). The new data appears from the next slot boundary.
- **Leading-zero suppression (lz_en=1):** digit k is suppressed if nibbles k..DIGITS-1 are all zero and k≠0. Digit 0 is never suppressed. A suppressed digit shows no segments and no dp.
- **Blanked digit:** the anode is still asserted in its slot, but segments and dp are off. This keeps the duty cycle uniform.
- **Dead time:** for prescaler values 0..DEAD_CYC-1, all anodes are inactive. Segments are already driven with the new digit during this time.
- **Decode:** hex 0-F per the package table, in active-high form. The output is XORed with ACTIVE_LOW.

## Timing

- **Reset values:** prescaler 0, index 0, all shadow and slot registers 0. an_out, seg_out and dp_out are at their inactive level: all ones when ACTIVE_LOW=1, zeros otherwise. frame_out is 0.
- **After reset release:** the first slot is digit 0 showing "0" (shadow = 0). The anode asserts at cycle DEAD_CYC after the first edge.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to pins.
- **Load latency:** load at cycle t makes the shadow valid at t+1. The value is visible at the first slot boundary after t+1.
- **Simultaneous load and slot boundary:** the slot uses the pre-load shadow, and the new value appears one slot later.
- **frame_out:** high for exactly one cycle, coincident with the first dead-time cycle of digit 0.
- **Reset mid-slot:** outputs go inactive immediately (asynchronously) and scanning restarts at digit 0.
- **DIGITS=1:** the index stays 0, and frame_out pulses every SLOT cycles.

## Structure

- **Package seg7_pkg:** the 16-entry hex-to-segment constant table (active-high, gfedcba), `0`=3F, `1`=06, `2`=5B, `3`=4F, `4`=66, `5`=6D, `6`=7D, `7`=07, `8`=7F, `9`=6F, `A`=77, `b`=7C, `C`=39, `d`=5E, `E`=79, `F`=71. It also holds the decode function and a width helper for the prescaler (clog2 of SLOT).
- **Sub-module seg7_prescaler:** a parametrised modulo-SLOT counter with a terminal-count output. All other logic stays in seg7_scan_mux.

## Test plan

All scenarios use DIGITS=4, CLK_HZ=4000, SCAN_HZ=250 (so SLOT=4), DEAD_CYC=1 and ACTIVE_LOW=1 unless stated otherwise.

1. **Reset:** hold RST_N=0 mid-slot → an_out=4'hF, seg_out=7'h7F, dp_out=1 asynchronously. After release, an_out goes 4'hF then 4'hE for 3 cycles, seg_out=~3F.
2. **Scan order:** load value 16'h12AF with dp_in=4'b0100 → an_out low bits cycle E,D,B,7 at 4 cycles each with segments ~71,~77,~5B,~06. dp_out=0 only during the digit-2 slot. frame_out pulses every 16 cycles.
3. **No tearing:** load 16'h0000 one cycle after a slot starts, then 16'h8888 at a slot boundary → the current slot keeps its old segments, and 8 (~7F) appears from the second boundary.
4. **Leading-zero suppression:** lz_en=1, value 16'h0070 → digits 3 and 2 are blank (seg 7F), digit 1 shows ~07, digit 0 shows ~3F. With value 0, only digit 0 shows "0".
5. **Blank and polarity:** blank_in=4'b0010 → the digit-1 anode is still active, but segments and dp are off. Rebuilding with ACTIVE_LOW=0 gives all outputs as the exact bitwise inverse.
6. **DIGITS=1, SLOT=2:** an_out alternates 1 (dead) / 0 (lit), and frame_out pulses every 2 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: the hex glyph table,
// the per-slot data record and small elaboration-time helpers.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Everything the currently lit digit needs, frozen at the slot boundary.
    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic       sup;
    } slot_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

    // Counter width able to hold 0..slot-1; never narrower than one bit.
    function automatic int cnt_width(input int slot);
        return (slot > 1) ? $clog2(slot) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Bundle between the board-level logic and the scan driver: display data and
// control in one direction, anode/segment pin drive in the other.
interface seg7_scan_mux_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  lz_en;
    logic [DIGITS-1:0]     an_out;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic                  frame_out;

    // Board-level side: supplies display data, observes the pins.
    modport master (
        output load, value_in, dp_in, blank_in, lz_en,
        input  an_out, seg_out, dp_out, frame_out
    );

    // Driver side.
    modport slave (
        input  load, value_in, dp_in, blank_in, lz_en,
        output an_out, seg_out, dp_out, frame_out
    );
endinterface

// File: rtl/seg7_prescaler.sv
// Free-running modulo-SLOT counter. Exposes the next count so the parent can
// register outputs that line up with the count value of the same cycle.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter int SLOT  = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap to zero at terminal count, otherwise increment.
    always_comb begin
        tc    = (cnt_q == LAST);
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver. Display data is captured
// into shadow registers on load and only transferred to the lit digit at a
// slot boundary, so a mid-slot update never tears the digit being shown.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int DEAD_CYC   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    seg7_scan_mux_if.slave bus
);
    localparam int   SLOT  = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int   CNT_W = cnt_width(SLOT);
    localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    if (SLOT < 2) begin : g_bad_slot
        $error("seg7_scan_mux: CLK_HZ/(SCAN_HZ*DIGITS) must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_mux: DIGITS must be in 1..8");
    end
    if (DEAD_CYC < 0 || DEAD_CYC >= SLOT) begin : g_bad_dead
        $error("seg7_scan_mux: DEAD_CYC must be below the slot length");
    end

    logic [CNT_W-1:0]    cnt_nxt;
    logic                tc;

    logic [4*DIGITS-1:0] val_q,   val_d;
    logic [DIGITS-1:0]   dp_q,    dp_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    slot_t               slot_q,  slot_d;

    logic [DIGITS-1:0]   an_q,    an_d;
    logic [6:0]          seg_q,   seg_d;
    logic                dpo_q,   dpo_d;
    logic                frame_q, frame_d;

    logic [IDX_W-1:0]    nxt_idx;
    logic [3:0]          nxt_nib;
    logic                nxt_dp;
    logic                nxt_blank;
    logic                hi_zero;
    logic                lit;
    logic                off;
    logic [DIGITS-1:0]   an_hot;

    seg7_prescaler #(
        .SLOT  (SLOT),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk     (CLK),
        .rst_n   (RST_N),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    // Shadow capture of the host's display data.
    always_comb begin
        val_d   = val_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (bus.load) begin
            val_d   = bus.value_in;
            dp_d    = bus.dp_in;
            blank_d = bus.blank_in;
        end
    end

    // Select the upcoming digit and freeze its data at the slot boundary.
    always_comb begin
        nxt_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        nxt_nib   = 4'h0;
        nxt_dp    = 1'b0;
        nxt_blank = 1'b0;
        hi_zero   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == nxt_idx) begin
                nxt_nib   = val_q[4*k +: 4];
                nxt_dp    = dp_q[k];
                nxt_blank = blank_q[k];
            end
            // Any non-zero nibble at or above the upcoming digit keeps it lit.
            if (k >= int'(nxt_idx) && val_q[4*k +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end

        idx_d  = idx_q;
        slot_d = slot_q;
        if (tc) begin
            idx_d        = nxt_idx;
            slot_d.nib   = nxt_nib;
            slot_d.dp    = nxt_dp;
            slot_d.blank = nxt_blank;
            slot_d.sup   = bus.lz_en && (nxt_idx != '0) && hi_zero;
        end
    end

    // Pin values for the cycle ahead; anodes stay dark during the dead time
    // while segments already carry the new digit.
    always_comb begin
        lit    = (cnt_nxt >= DEAD_CNT);
        off    = slot_d.blank | slot_d.sup;
        an_hot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (lit && IDX_W'(k) == idx_d) begin
                an_hot[k] = 1'b1;
            end
        end
        an_d    = an_hot ^ {DIGITS{POL}};
        seg_d   = (off ? 7'h00 : hex_to_seg(slot_d.nib)) ^ {7{POL}};
        dpo_d   = (slot_d.dp & ~off) ^ POL;
        frame_d = tc && (nxt_idx == '0);
    end

    // State and output registers; outputs reset to their inactive level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            val_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
            an_q    <= {DIGITS{POL}};
            seg_q   <= {7{POL}};
            dpo_q   <= POL;
            frame_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            frame_q <= frame_d;
        end
    end

    assign bus.an_out    = an_q;
    assign bus.seg_out   = seg_q;
    assign bus.dp_out    = dpo_q;
    assign bus.frame_out = frame_q;

endmodule
